// File: rtl/hazard_controller.sv
// Pipeline hazard/sequencing controller: load-use stalls, taken-branch squash,
// mul/div issue scheduling with a busy window, and a saturating stall counter.
module hazard_controller #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_IFID,
  input  logic [4:0]       RS2_IFID,
  input  logic             usesRs1_IFID,
  input  logic             usesRs2_IFID,
  input  logic [4:0]       RD_IDEX,
  input  logic             memRead_IDEX,
  input  logic             md_IFID,
  input  logic             hiloUse_IFID,
  input  logic             branchTaken_EX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             bubble_IDEX,
  output logic             flush_IFID,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [0:0]    S_RUN    = 1'b0;
  localparam logic [0:0]    S_BUSY   = 1'b1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             lu, mh, stall, issue;

  assign lu = memRead_IDEX && (RD_IDEX != 5'd0) &&
              ((usesRs1_IFID && (RD_IDEX == RS1_IFID)) ||
               (usesRs2_IFID && (RD_IDEX == RS2_IFID)));
  assign mh    = md_busy && (md_IFID || hiloUse_IFID);
  assign stall = (lu || mh) && !branchTaken_EX;
  assign issue = md_IFID && (state_q == S_RUN) && !lu && !branchTaken_EX;

  assign md_busy      = (state_q == S_BUSY);
  assign stall_cycles = scnt_q;

  // Reset forces a squash-everything posture; the taken branch outranks any stall.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    bubble_IDEX = 1'b0;
    flush_IFID  = 1'b0;
    md_start    = 1'b0;
    if (!rst) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      bubble_IDEX = 1'b1;
      flush_IFID  = 1'b1;
    end else if (branchTaken_EX) begin
      bubble_IDEX = 1'b1;
      flush_IFID  = 1'b1;
    end else begin
      md_start = issue;
      if (stall) begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        bubble_IDEX = 1'b1;
      end
    end
  end

  // A taken branch never aborts the busy window: the mul/div is older.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_RUN) begin
      if (issue) begin
        state_d = S_BUSY;
        cnt_d   = CNT_LOAD;
      end
    end else if (cnt_q == '0) begin
      state_d = S_RUN;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (!PCWrite && !branchTaken_EX && (scnt_q != '1))
      scnt_d = scnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// Directed + randomized bench for hazard_controller against a cycle-count reference model.
module tb_hazard_controller;
  localparam int MDC  = 4;
  localparam int CNTW = 4;
  localparam int SMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, mr, md, hilo, br;
  logic pcw, ifw, bub, fl, mds, mdb;
  logic [CNTW-1:0] sc;

  int tests = 0;
  int fails = 0;
  int busy_left = 0;   // cycles of mul/div occupancy still ahead
  int scnt = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MD_CYCLES(MDC), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst),
    .RS1_IFID(rs1), .RS2_IFID(rs2), .usesRs1_IFID(u1), .usesRs2_IFID(u2),
    .RD_IDEX(rd), .memRead_IDEX(mr), .md_IFID(md), .hiloUse_IFID(hilo),
    .branchTaken_EX(br),
    .PCWrite(pcw), .IFIDWrite(ifw), .bubble_IDEX(bub), .flush_IFID(fl),
    .md_start(mds), .md_busy(mdb), .stall_cycles(sc)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; md = 0; hilo = 0; br = 0;
  endtask

  task automatic rand_in(input int narrow);
    rs1 = narrow ? 5'($urandom_range(3)) : 5'($urandom);
    rs2 = narrow ? 5'($urandom_range(3)) : 5'($urandom);
    rd  = narrow ? 5'($urandom_range(3)) : 5'($urandom);
    u1 = 1'($urandom); u2 = 1'($urandom); mr = 1'($urandom);
    md = ($urandom_range(3) == 0); hilo = ($urandom_range(3) == 0);
    br = ($urandom_range(7) == 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pcw"}, pcw, 0);
    chk({tag, ".ifw"}, ifw, 0);
    chk({tag, ".bub"}, bub, 1);
    chk({tag, ".fl"},  fl, 1);
    chk({tag, ".mds"}, mds, 0);
    chk({tag, ".mdb"}, mdb, 0);
    chk({tag, ".sc"},  sc, 0);
  endtask

  // Inputs are already applied just after a posedge; check mid-cycle, then advance.
  task automatic cyc(input string tag);
    bit lu, mh, stall, issue, busy;
    busy  = busy_left > 0;
    lu    = mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
    mh    = busy && (md || hilo);
    stall = (lu || mh) && !br;
    issue = md && !busy && !lu && !br;
    #4;
    chk({tag, ".pcw"}, pcw, int'(!stall));
    chk({tag, ".ifw"}, ifw, int'(!stall));
    chk({tag, ".bub"}, bub, int'(stall || br));
    chk({tag, ".fl"},  fl, int'(br));
    chk({tag, ".mds"}, mds, int'(issue));
    chk({tag, ".mdb"}, mdb, int'(busy));
    chk({tag, ".sc"},  sc, scnt);
    @(posedge clk);
    if (issue) busy_left = MDC;
    else if (busy_left > 0) busy_left--;
    if (stall && scnt < SMAX) scnt++;
    #1;
  endtask

  initial begin
    idle();
    // reset held 3 cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      rand_in(0);
      #1 chk_reset("rst_hold");
      @(posedge clk); #1;
    end
    rst = 1'b1;
    idle();
    cyc("rst_release");
    chk("release.pcw_free", pcw, 1);

    // load-use: one stall, then the bubble removes memRead
    mr = 1; rd = 5; rs2 = 5; u2 = 1;
    cyc("lu_stall");
    idle();
    cyc("lu_after");
    chk("lu.count_one", sc, 1);
    mr = 1; rd = 0; rs2 = 0; u2 = 1;
    cyc("lu_rd0");

    // mul/div window with dependent mfhi
    idle(); md = 1;
    cyc("md_issue");
    md = 0; hilo = 1;
    for (int i = 0; i < 5; i++) cyc("md_hilo");
    idle();
    for (int i = 0; i < 4; i++) cyc("md_drain");

    // branch beats lu and md issue
    mr = 1; rd = 5; rs2 = 5; u2 = 1; md = 1; br = 1;
    cyc("br_prio");
    idle();
    cyc("br_after");

    // back-to-back mul/div
    md = 1;
    cyc("b2b_first");
    for (int i = 0; i < 5; i++) cyc("b2b_second");
    idle();
    for (int i = 0; i < 5; i++) cyc("b2b_drain");

    // reset in the middle of the busy window
    md = 1;
    cyc("mrst_issue");
    idle();
    cyc("mrst_busy");
    #2 rst = 1'b0;
    #1 chk_reset("mrst_async");
    busy_left = 0; scnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    md = 1;
    cyc("mrst_reissue");
    idle();
    for (int i = 0; i < 5; i++) cyc("mrst_drain");

    // held load-use drives the counter to saturation
    mr = 1; rd = 7; rs1 = 7; u1 = 1;
    for (int i = 0; i < 20; i++) cyc("sat");
    chk("sat.final", sc, SMAX);
    idle();

    // randomized traffic, occasionally with a reset pulse
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        rand_in(1);
        rst = 1'b0;
        #1 chk_reset("rnd_rst");
        busy_left = 0; scnt = 0;
        @(posedge clk); #1;
        rst = 1'b1;
      end
      rand_in(1);
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage MIPS32 core; it sits next to the forwarding unit and owns every case that forwarding cannot cover. It detects load-use hazards and stalls IF/ID one cycle with a bubble into ID/EX. It squashes wrong-path instructions on taken branches and jumps. It schedules the shared multi-cycle multiply/divide unit: it issues starts, tracks the unit's busy window and holds dependent or competing instructions in ID. A saturating stall-cycle counter is provided for performance measurement.

## Interface
- MD_CYCLES, 32, multiply/divide latency in cycles; legal range 2..256
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- RS1_IFID  in  5  rs field of the instruction in ID
- RS2_IFID  in  5  rt field of the instruction in ID
- usesRs1_IFID  in  1  instruction in ID reads RS1
- usesRs2_IFID  in  1  instruction in ID reads RS2
- RD_IDEX  in  5  destination register of the instruction in EX
- memRead_IDEX  in  1  instruction in EX is a load
- md_IFID  in  1  instruction in ID is mult/multu/div/divu
- hiloUse_IFID  in  1  instruction in ID is mfhi/mflo
- branchTaken_EX  in  1  branch or jump resolved taken in EX this cycle
- PCWrite  out  1  1 = PC updates
- IFIDWrite  out  1  1 = IF/ID register updates
- bubble_IDEX  out  1  1 = ID/EX loads a NOP and control bits are zeroed
- flush_IFID  out  1  1 = IF/ID loads a NOP
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_busy  out  1  mul/div unit is occupied
- stall_cycles  out  CNT_W  count of cycles with PCWrite=0, saturating

## Operation
- State machine: RUN and MD_BUSY. A down-counter of width clog2(MD_CYCLES) runs alongside it.
- Reset (rst=0), asynchronous:
  - State goes to RUN; the counter, md_busy and stall_cycles clear to 0.
  - While rst=0 the outputs are forced to PCWrite=0, IFIDWrite=0, bubble_IDEX=1, flush_IFID=1, md_start=0.
  - stall_cycles does not count during reset.
- Load-use hazard, combinational: lu = memRead_IDEX && RD_IDEX!=0 && ((usesRs1_IFID && RD_IDEX==RS1_IFID) || (usesRs2_IFID && RD_IDEX==RS2_IFID)).
- Mul/div structural hazard, combinational: mh = md_busy && (md_IFID || hiloUse_IFID).
- Stall condition: stall = (lu || mh) && !branchTaken_EX.
  - When stall=1: PCWrite=0, IFIDWrite=0, bubble_IDEX=1, flush_IFID=0.
- Taken branch has the highest priority. When branchTaken_EX=1: PCWrite=1, IFIDWrite=1, flush_IFID=1, bubble_IDEX=1, md_start=0.
  - This overrides lu and mh, because the instruction in ID is on the wrong path.
- Otherwise (no stall, no taken branch): PCWrite=1, IFIDWrite=1, bubble_IDEX=0, flush_IFID=0.
- Issue: md_start = md_IFID && state==RUN && !lu && !branchTaken_EX.
  - On that edge the counter loads MD_CYCLES-1 and the state moves to MD_BUSY.
- MD_BUSY:
  - md_busy=1.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, the state returns to RUN at the next edge.
  - Instructions that are neither mul/div nor mfhi/mflo flow freely.
  - A taken branch does not abort MD_BUSY, because the mul/div instruction is older than the branch.
- stall_cycles increments by 1 on each edge where rst=1 and PCWrite=0 and branchTaken_EX=0. It holds at 2^CNT_W-1.
- RD_IDEX==0 never causes a stall.

## Timing
- PCWrite, IFIDWrite, bubble_IDEX, flush_IFID and md_start are combinational from the inputs and the current state, with no latency.
- md_busy is registered.
- Mul/div issued in cycle T (md_start=1 at T):
  - md_busy=1 in cycles T+1..T+MD_CYCLES.
  - md_busy=0 from T+MD_CYCLES+1.
  - A dependent mfhi/mflo or a second mul/div held in ID issues at T+MD_CYCLES+1 at the earliest.
- A load-use stall lasts exactly 1 cycle: the bubble makes memRead_IDEX=0 on the next cycle.
- lu and mh together still give one stall per cycle. The stall lasts until both conditions clear.
- A reset mid-MD_BUSY aborts the sequence. After rst rises the state is RUN, md_busy=0 and no md_start is pending.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs -> md_busy=0, stall_cycles=0, PCWrite=0, flush_IFID=1. After release with idle inputs -> PCWrite=1, bubble_IDEX=0.
- Load-use: memRead_IDEX=1, RD_IDEX=5, RS2_IFID=5, usesRs2_IFID=1 -> exactly 1 cycle of PCWrite=0, IFIDWrite=0, bubble_IDEX=1, and stall_cycles goes 0->1. Repeat with RD_IDEX=0 -> no stall.
- Mul/div window, MD_CYCLES=4: md_IFID=1 at T -> md_start=1 at T only, md_busy=1 for T+1..T+4. With hiloUse_IFID=1 held from T+1 -> 4 stall cycles, then PCWrite=1 at T+5.
- Branch priority: branchTaken_EX=1 in the same cycle as lu=1 and md_IFID=1 -> flush_IFID=1, bubble_IDEX=1, PCWrite=1, md_start=0, and stall_cycles unchanged.
- Back-to-back mul/div, MD_CYCLES=4: a second md_IFID arrives right after the first issues -> stalled 4 cycles, then md_start at T+5.
- Reset mid-busy (rst=0 at T+2), then a counter-saturation check with CNT_W=4 and a held stall -> md_busy=0 after reset; stall_cycles stops at 15.
